patch_reorder_buf: RTL and testbench
====================================

// Module: patch_reorder_buf
// PURPOSE
//  Windowed reorder buffer: accepts out-of-order patch results (number + FP word) and emits them strictly in patch order.
//  Output has a valid/ready handshake with downstream backpressure.
//  Detects window overrun, duplicate/late patches and stray frame markers, with a sticky error code and a clear input.
//  Sits between the patch compute engines and the per-frame accumulator, one instance per channel.
// PARAMETERS
//  DELAY        1     simulation #delay on every nonblocking assignment
//  FP_SIZE      32    data word width
//  N_PATCH      1000  patches per frame; in_num width NW = log2(N_PATCH+1), so the all-ones value is never a patch number
//  SYNC_WINDOW  64    reorder depth; power of two, <= N_PATCH; slot = in_num[log2(SYNC_WINDOW)-1:0]
// PORTS
//  CLK       in   1        clock
//  RESET     in   1        asynchronous, active-high reset
//  in_val    in   1        input word valid
//  in_ack    out  1        input accepted when in_val && in_ack
//  in_num    in   NW       patch number; all-ones = marker word
//  in_data   in   FP_SIZE  patch result; with the marker, value 1 = start of frame (SOF)
//  out_val   out  1        output word valid
//  out_rdy   in   1        downstream ready
//  out_num   out  NW       patch number of output word
//  out_data  out  FP_SIZE  patch result
//  out_sof   out  1        out_num == 0
//  out_eof   out  1        out_num == N_PATCH-1
//  fill      out  log2(SYNC_WINDOW+1)  number of slots currently holding a patch
//  err       out  1        sticky error flag
//  err_code  out  2        1 = ahead of window / out of range, 2 = duplicate or late, 3 = SOF inside a frame
//  clr_err   in   1        leave ERROR: flush the buffer, return to SOF_WAIT
// BEHAVIOUR
//  Reset values: state=SOF_WAIT; all slot flags 0; exp_num=0; out_val=0; out_num=0; out_data=0; err=0; err_code=0; fill=0.
//  in_ack = (state==SOF_WAIT || state==FRAME). No backpressure on the input; overrun is an error, not a stall.
//  SOF_WAIT:
//   - Accepted marker with in_data==1 -> FRAME, exp_num=0.
//   - Other markers and non-marker words are dropped silently.
//  FRAME, accepted non-marker word w:
//   - exp_num <= w < min(exp_num+SYNC_WINDOW, N_PATCH): write data to slot, set its flag.
//     Compare in NW+1 bits so there is no wrap.
//   - w >= exp_num+SYNC_WINDOW, or w >= N_PATCH -> ERROR, code 1.
//   - w < exp_num, or the slot flag is already set -> ERROR, code 2.
//  FRAME, marker: SOF -> ERROR, code 3; any other marker is ignored.
//  Pop, in FRAME only:
//   - Condition: flag[slot(exp_num)] && (!out_val || out_rdy).
//   - Loads out_* from the slot, sets out_val, clears the flag, increments exp_num.
//   - Popping N_PATCH-1 -> SOF_WAIT, exp_num=0.
//  Output register: out_val drops when out_rdy && out_val and no pop occurs that cycle.
//   - out_* hold their values while out_val && !out_rdy.
//  Latency and throughput:
//   - In-order word accepted in cycle t -> out_val in t+2 (flag set at t+1, pop at t+1).
//   - Sustained rate is 1 word/cycle with out_rdy high.
//  Same-cycle accept and pop:
//   - They always target different slots (same slot would be a code-2 error).
//   - fill goes +1 on accept, -1 on pop, net 0 if both.
//  Last word of a frame: may still be in the output register (out_val && !out_rdy) on entering SOF_WAIT.
//   It is held until taken, and a new frame's pops wait behind it.
//  ERROR:
//   - in_ack=0, no pops.
//   - An out_val word already presented completes its handshake.
//   - err=1; err_code is latched from the first fault only.
//   - clr_err: all flags cleared, fill=0, exp_num=0, err=0, err_code=0, next state SOF_WAIT.
//  Simultaneous faults in one cycle: precedence code 3 > 1 > 2.
//  RESET asserted mid-frame: immediate async return to reset values; buffered patches are discarded.
// TESTING
//  1 SOF, then patches 0..N_PATCH-1 in order, out_rdy=1:
//    -> out_num 0..N_PATCH-1 contiguous; out_val first at accept+2; out_sof on 0; out_eof on N_PATCH-1.
//  2 SOF, then 3,1,0,2 (SYNC_WINDOW=4, N_PATCH=4):
//    -> outputs 0,1,2,3 in order; fill peaks at 3; returns to SOF_WAIT.
//  3 out_rdy=0 for 20 cycles with the window full:
//    -> out_* stable, fill==SYNC_WINDOW; patch exp_num+SYNC_WINDOW arriving -> err=1, err_code=1, in_ack=0.
//  4 Patch 5 sent twice:
//    -> err_code=2. Patch 0 arriving after 0 has popped -> err_code=2.
//  5 SOF marker mid-frame -> err_code=3; clr_err pulse -> err=0, fill=0, in_ack=1; next SOF frame is output correctly.
//  6 RESET asserted between clock edges mid-frame:
//    -> out_val=0, fill=0 with no clock edge needed; a clean frame follows.

Source files
------------

// File: rtl/patch_reorder_buf_if.sv
// Patch reorder buffer bus: input word stream, ordered output stream, status and error clear.
// Purely structural; no latency of its own.
// Backpressure is carried by out_rdy. in_ack only closes the input while the block is in error.
interface patch_reorder_buf_if #(
  parameter int FP_SIZE = 32,
  parameter int NW      = 10,
  parameter int FW      = 7
);
  logic               in_val;
  logic               in_ack;
  logic [NW-1:0]      in_num;
  logic [FP_SIZE-1:0] in_data;
  logic               out_val;
  logic               out_rdy;
  logic [NW-1:0]      out_num;
  logic [FP_SIZE-1:0] out_data;
  logic               out_sof;
  logic               out_eof;
  logic [FW-1:0]      fill;
  logic               err;
  logic [1:0]         err_code;
  logic               clr_err;

  // Producer/consumer side (compute engines plus accumulator, or a testbench)
  modport master (
    output in_val, in_num, in_data, out_rdy, clr_err,
    input  in_ack, out_val, out_num, out_data, out_sof, out_eof, fill, err, err_code
  );

  // Reorder buffer side
  modport slave (
    input  in_val, in_num, in_data, out_rdy, clr_err,
    output in_ack, out_val, out_num, out_data, out_sof, out_eof, fill, err, err_code
  );
endinterface

// File: rtl/patch_reorder_buf.sv
// Windowed reorder buffer: takes out-of-order patch results and emits them strictly in patch order.
// Latency: an in-order word accepted in cycle t shows on out_val in cycle t+2. Throughput is 1 word/cycle.
// Backpressure: out_rdy stalls pops only. The input is never stalled; a window overrun is a sticky error.
module patch_reorder_buf #(
  parameter int FP_SIZE     = 32,
  parameter int N_PATCH     = 1000,
  parameter int SYNC_WINDOW = 64,
  localparam int NW = $clog2(N_PATCH + 1),
  localparam int SB = $clog2(SYNC_WINDOW),
  localparam int FW = $clog2(SYNC_WINDOW + 1)
) (
  input logic                clk,
  input logic                rst,
  patch_reorder_buf_if.slave bus
);

  typedef enum logic [1:0] {SOF_WAIT, FRAME, ERROR} state_t;

  state_t             state_q, state_d;
  logic [SYNC_WINDOW-1:0] flag_q, flag_d;
  logic [FP_SIZE-1:0] mem_q [SYNC_WINDOW];
  logic [NW-1:0]      exp_num_q, exp_num_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               out_val_q, out_val_d;
  logic [NW-1:0]      out_num_q, out_num_d;
  logic [FP_SIZE-1:0] out_data_q, out_data_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;

  logic          in_ack;
  logic          accept, is_marker, is_sof, in_frame, word_in;
  logic [NW:0]   num_x, exp_x;
  logic [SB-1:0] wslot, rslot;
  logic          f_sof, f_ahead, f_late, fault, wr, pop, last_pop, clr;
  logic [1:0]    fault_code;

  // Input decode and fault classification. Compares use one extra bit so the window end never wraps.
  always_comb begin
    accept    = bus.in_val && in_ack;
    is_marker = &bus.in_num;
    is_sof    = is_marker && (bus.in_data == FP_SIZE'(1));
    in_frame  = (state_q == FRAME);
    num_x     = {1'b0, bus.in_num};
    exp_x     = {1'b0, exp_num_q};
    wslot     = bus.in_num[SB-1:0];
    rslot     = exp_num_q[SB-1:0];
    word_in   = in_frame && accept && !is_marker;
    f_sof     = in_frame && accept && is_sof;
    f_ahead   = word_in && ((num_x >= exp_x + (NW+1)'(SYNC_WINDOW)) ||
                            (num_x >= (NW+1)'(N_PATCH)));
    f_late    = word_in && ((num_x < exp_x) || flag_q[wslot]);
    fault     = f_sof || f_ahead || f_late;
    // A word can trip several checks at once: stray SOF beats overrun beats duplicate/late
    fault_code = f_sof ? 2'd3 : (f_ahead ? 2'd1 : 2'd2);
    wr        = word_in && !f_ahead && !f_late;
    // The next patch in order leaves as soon as the output register is free or being drained
    pop       = in_frame && flag_q[rslot] && (!bus.out_val || bus.out_rdy);
    last_pop  = pop && (exp_num_q == NW'(N_PATCH - 1));
    clr       = (state_q == ERROR) && bus.clr_err;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SOF_WAIT;
    else     state_q <= state_d;
  end

  // Next-state logic: frame entry on SOF, exit after the last patch pops or on any fault
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SOF_WAIT: if (accept && is_sof) state_d = FRAME;
      FRAME: begin
        if (fault)         state_d = ERROR;
        else if (last_pop) state_d = SOF_WAIT;
      end
      ERROR:    if (bus.clr_err) state_d = SOF_WAIT;
      default:  state_d = SOF_WAIT;
    endcase
  end

  // State-decoded outputs: the input is open except while in error
  always_comb begin
    in_ack = (state_q == SOF_WAIT) || (state_q == FRAME);
  end

  // Datapath next-state: slot flags, expected number, occupancy, output register, sticky error
  always_comb begin
    flag_d     = flag_q;
    exp_num_d  = exp_num_q;
    fill_d     = fill_q;
    out_val_d  = out_val_q;
    out_num_d  = out_num_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    // Accept and pop never hit the same slot in one cycle, so both updates can apply
    if (wr)  flag_d[wslot] = 1'b1;
    if (pop) flag_d[rslot] = 1'b0;

    if (wr && !pop)      fill_d = fill_q + FW'(1);
    else if (!wr && pop) fill_d = fill_q - FW'(1);

    if (pop) begin
      out_val_d  = 1'b1;
      out_num_d  = exp_num_q;
      out_data_d = mem_q[rslot];
      exp_num_d  = last_pop ? '0 : exp_num_q + NW'(1);
    end else if (bus.out_rdy) begin
      out_val_d = 1'b0;
    end

    if (state_q == SOF_WAIT && accept && is_sof) exp_num_d = '0;

    // Only FRAME can fault and ERROR closes the input, so the first fault's code is the one kept
    if (fault) begin
      err_d      = 1'b1;
      err_code_d = fault_code;
    end

    // Clearing flushes the window; a word already in the output register still completes
    if (clr) begin
      flag_d     = '0;
      fill_d     = '0;
      exp_num_d  = '0;
      err_d      = 1'b0;
      err_code_d = 2'd0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q     <= '0;
      exp_num_q  <= '0;
      fill_q     <= '0;
      out_val_q  <= 1'b0;
      out_num_q  <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      flag_q     <= flag_d;
      exp_num_q  <= exp_num_d;
      fill_q     <= fill_d;
      out_val_q  <= out_val_d;
      out_num_q  <= out_num_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Slot storage; contents are only meaningful where the matching flag is set, so no reset
  always_ff @(posedge clk) begin
    if (wr) mem_q[wslot] <= bus.in_data;
  end

  assign bus.in_ack   = in_ack;
  assign bus.out_val  = out_val_q;
  assign bus.out_num  = out_num_q;
  assign bus.out_data = out_data_q;
  assign bus.out_sof  = (out_num_q == '0);
  assign bus.out_eof  = (out_num_q == NW'(N_PATCH - 1));
  assign bus.fill     = fill_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_patch_reorder_buf.sv
// Directed bench for patch_reorder_buf with a small window (N_PATCH=8, SYNC_WINDOW=4).
// Expected output words are queued as stimulus is driven and compared on each output handshake.
// Status outputs are compared directly at fixed points in the sequence.
module tb_patch_reorder_buf;
  localparam int NP = 8;
  localparam int SW = 4;
  localparam int NW = $clog2(NP + 1);
  localparam int FW = $clog2(SW + 1);
  localparam logic [NW-1:0] MARK = '1;

  typedef struct packed {
    logic [NW-1:0] num;
    logic [31:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   max_fill = 0;
  exp_t sb[$];

  patch_reorder_buf_if #(.FP_SIZE(32), .NW(NW), .FW(FW)) bus ();

  patch_reorder_buf #(.FP_SIZE(32), .N_PATCH(NP), .SYNC_WINDOW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] dv(input int f, input int n);
    return 32'hC0DE_0000 | 32'(f << 8) | 32'(n);
  endfunction

  task automatic send(input logic [NW-1:0] n, input logic [31:0] d);
    bus.in_val  = 1'b1;
    bus.in_num  = n;
    bus.in_data = d;
    @(posedge clk); #1;
    bus.in_val  = 1'b0;
  endtask

  task automatic sof();
    send(MARK, 32'd1);
  endtask

  task automatic expect_w(input int f, input int n);
    exp_t e;
    e.num  = NW'(n);
    e.data = dv(f, n);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    bus.clr_err = 1'b1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
  endtask

  // Output monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(bus.fill) > max_fill) max_fill = int'(bus.fill);
      if (bus.out_val && bus.out_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'(bus.out_num), 64'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_num",  64'(bus.out_num),  64'(e.num));
          chk("out_data", 64'(bus.out_data), 64'(e.data));
          chk("out_sof",  64'(bus.out_sof),  64'(e.num == 0));
          chk("out_eof",  64'(bus.out_eof),  64'(e.num == NW'(NP - 1)));
        end
      end
    end
  end

  initial begin
    logic [NW-1:0] hold_num;
    logic [31:0]   hold_data;
    rst = 1'b1;
    bus.in_val = 1'b0; bus.in_num = '0; bus.in_data = '0;
    bus.out_rdy = 1'b1; bus.clr_err = 1'b0;
    #23 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_out_val",  64'(bus.out_val),  64'd0);
    chk("rst_out_num",  64'(bus.out_num),  64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_err",      64'(bus.err),      64'd0);
    chk("rst_err_code", 64'(bus.err_code), 64'd0);
    chk("rst_fill",     64'(bus.fill),     64'd0);
    chk("rst_in_ack",   64'(bus.in_ack),   64'd1);

    // 1: in-order frame, latency of the first word
    sof();
    for (int n = 0; n < NP; n++) expect_w(1, n);
    send(0, dv(1, 0));
    chk("t1_lat_t1", 64'(bus.out_val), 64'd0);
    @(posedge clk); #1;
    chk("t1_lat_t2", 64'(bus.out_val), 64'd1);
    for (int n = 1; n < NP; n++) send(NW'(n), dv(1, n));
    idle(4);
    chk("t1_drained", 64'(sb.size()), 64'd0);
    chk("t1_fill",    64'(bus.fill),  64'd0);
    // Back in SOF_WAIT: a plain word is dropped silently (no output, no error)
    send(3, dv(1, 3));
    idle(3);
    chk("t1_sofwait_err", 64'(bus.err),    64'd0);
    chk("t1_sofwait_ack", 64'(bus.in_ack), 64'd1);

    // 2: out-of-order start 3,1,0,2 then the rest in order
    max_fill = 0;
    sof();
    for (int n = 0; n < NP; n++) expect_w(2, n);
    send(3, dv(2, 3)); send(1, dv(2, 1)); send(0, dv(2, 0)); send(2, dv(2, 2));
    for (int n = 4; n < NP; n++) send(NW'(n), dv(2, n));
    idle(4);
    chk("t2_max_fill", 64'(max_fill),   64'd3);
    chk("t2_drained",  64'(sb.size()),  64'd0);
    chk("t2_fill",     64'(bus.fill),   64'd0);
    chk("t2_in_ack",   64'(bus.in_ack), 64'd1);

    // 3: full window under backpressure, then overrun
    sof();
    bus.out_rdy = 1'b0;
    expect_w(3, 0);
    for (int n = 0; n <= SW; n++) send(NW'(n), dv(3, n));
    idle(2);
    chk("t3_fill_full", 64'(bus.fill),     64'(SW));
    chk("t3_out_val",   64'(bus.out_val),  64'd1);
    chk("t3_out_num",   64'(bus.out_num),  64'd0);
    chk("t3_out_data",  64'(bus.out_data), 64'(dv(3, 0)));
    hold_num  = bus.out_num;
    hold_data = bus.out_data;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("t3_hold_num",  64'(bus.out_num),  64'(NW'(0)));
      chk("t3_hold_data", 64'(bus.out_data), 64'(dv(3, 0)));
      chk("t3_hold_val",  64'(bus.out_val),  64'd1);
      chk("t3_hold_fill", 64'(bus.fill),     64'(SW));
    end
    send(NW'(1 + SW), dv(3, 1 + SW));
    chk("t3_err",      64'(bus.err),      64'd1);
    chk("t3_err_code", 64'(bus.err_code), 64'd1);
    chk("t3_in_ack",   64'(bus.in_ack),   64'd0);
    chk("t3_held_num", 64'(bus.out_num),  64'(hold_num));
    chk("t3_held_dat", 64'(bus.out_data), 64'(hold_data));
    bus.out_rdy = 1'b1;
    idle(1);
    chk("t3_out_drop", 64'(bus.out_val),  64'd0);
    chk("t3_drained",  64'(sb.size()),    64'd0);
    clr_pulse();
    chk("t3_clr_err",  64'(bus.err),      64'd0);
    chk("t3_clr_code", 64'(bus.err_code), 64'd0);
    chk("t3_clr_fill", 64'(bus.fill),     64'd0);
    chk("t3_clr_ack",  64'(bus.in_ack),   64'd1);

    // 4a: duplicate patch 5
    sof();
    for (int n = 0; n <= 5; n++) expect_w(4, n);
    for (int n = 0; n <= 5; n++) send(NW'(n), dv(4, n));
    send(5, dv(4, 5));
    chk("t4_dup_err",  64'(bus.err),      64'd1);
    chk("t4_dup_code", 64'(bus.err_code), 64'd2);
    chk("t4_dup_ack",  64'(bus.in_ack),   64'd0);
    idle(3);
    chk("t4_dup_drain", 64'(sb.size()), 64'd0);
    clr_pulse();

    // 4b: late patch 0 after it has already popped
    sof();
    expect_w(5, 0);
    send(0, dv(5, 0));
    idle(3);
    send(0, dv(5, 0));
    chk("t4_late_err",  64'(bus.err),      64'd1);
    chk("t4_late_code", 64'(bus.err_code), 64'd2);
    idle(2);
    chk("t4_late_drain", 64'(sb.size()), 64'd0);
    clr_pulse();

    // 5: stray SOF inside a frame, clear, then a scrambled clean frame
    sof();
    expect_w(6, 0); expect_w(6, 1);
    send(0, dv(6, 0)); send(1, dv(6, 1));
    sof();
    idle(2);
    chk("t5_err",      64'(bus.err),      64'd1);
    chk("t5_err_code", 64'(bus.err_code), 64'd3);
    clr_pulse();
    chk("t5_clr_err",  64'(bus.err),      64'd0);
    chk("t5_clr_fill", 64'(bus.fill),     64'd0);
    chk("t5_clr_ack",  64'(bus.in_ack),   64'd1);
    sof();
    for (int n = 0; n < NP; n++) expect_w(7, n);
    for (int p = 0; p < NP; p += 2) begin
      send(NW'(p + 1), dv(7, p + 1));
      send(NW'(p),     dv(7, p));
    end
    idle(5);
    chk("t5_frame_drain", 64'(sb.size()), 64'd0);
    chk("t5_frame_err",   64'(bus.err),   64'd0);

    // 6: asynchronous reset mid-frame between clock edges
    sof();
    bus.out_rdy = 1'b0;
    send(0, dv(8, 0)); send(1, dv(8, 1)); send(2, dv(8, 2));
    idle(1);
    chk("t6_pre_val",  64'(bus.out_val), 64'd1);
    chk("t6_pre_fill", 64'(bus.fill),    64'd2);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_val",  64'(bus.out_val), 64'd0);
    chk("t6_rst_fill", 64'(bus.fill),    64'd0);
    chk("t6_rst_err",  64'(bus.err),     64'd0);
    #2 rst = 1'b0;
    bus.out_rdy = 1'b1;
    idle(1);
    sof();
    for (int n = 0; n < NP; n++) expect_w(9, n);
    for (int n = 0; n < NP; n++) send(NW'(n), dv(9, n));
    idle(4);
    chk("t6_frame_drain", 64'(sb.size()), 64'd0);
    chk("t6_frame_fill",  64'(bus.fill),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
